// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int OPCODE_LSB = 2;
    localparam int OPCODE_MSB = 6;
    localparam int FUNC3_LSB  = 12;
    localparam int FUNC3_MSB  = 14;
    localparam int FUNC7_LSB  = 25;
    localparam int FUNC7_MSB  = 31;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular prefetch buffer with synchronous push/pop/flush and an occupancy count.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, in-order memory requests, prefetch buffering
// and redirect handling, presenting a pre-sliced head instruction to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [4:0]      opcode,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic            illegal
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic            armed;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_next;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     in_flight;
    logic [2*XLEN-1:0] head;
    logic [XLEN-1:0] head_inst;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] resp_pc;
    logic            active;
    logic            redirect_now;
    logic            issue;
    logic            push;
    logic            pop;

    assign active       = (state != IDLE);
    assign redirect_now = redirect && active;
    assign in_flight    = {1'b0, outstanding} + {1'b0, fifo_count};

    assign imem_req  = (state == RUN) && !redirect && (in_flight < (CW+1)'(FIFO_DEPTH));
    assign imem_addr = fetch_pc;
    assign issue     = imem_req && imem_gnt;

    // Outside DRAIN every pending request is on the current path and sequential,
    // so the oldest one sits outstanding words behind the fetch PC.
    assign resp_pc = fetch_pc - XLEN'({outstanding, 2'b00});
    assign push    = (state == RUN) && !redirect && imem_rvalid;
    assign pop     = inst_valid && inst_ready;

    always_comb begin
        state_next       = state;
        fetch_pc_next    = fetch_pc;
        outstanding_next = outstanding;

        if (issue || (redirect_now && imem_gnt))
            outstanding_next = outstanding_next + CW'(1);
        if (imem_rvalid && active)
            outstanding_next = outstanding_next - CW'(1);
        if (issue)
            fetch_pc_next = fetch_pc + XLEN'(4);

        case (state)
            IDLE:    if (armed) state_next = RUN;
            RUN:     state_next = RUN;
            DRAIN:   if (outstanding_next == '0) state_next = RUN;
            default: state_next = IDLE;
        endcase

        if (redirect_now) begin
            fetch_pc_next = redirect_pc & ~XLEN'(3);
            state_next    = (outstanding_next != '0) ? DRAIN : RUN;
        end
    end

    // armed holds IDLE for one full cycle after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            armed       <= 1'b0;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
        end else begin
            state       <= state_next;
            armed       <= 1'b1;
            fetch_pc    <= fetch_pc_next;
            outstanding <= outstanding_next;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({imem_rdata, resp_pc}),
        .pop       (pop),
        .flush     (redirect_now),
        .head      (head),
        .count     (fifo_count)
    );

    assign head_inst  = head[2*XLEN-1:XLEN];
    assign head_pc    = head[XLEN-1:0];
    assign inst_valid = (fifo_count != '0);
    assign inst       = inst_valid ? head_inst : XLEN'(NOP);
    assign inst_pc    = inst_valid ? head_pc : fetch_pc;
    assign opcode     = inst[OPCODE_MSB:OPCODE_LSB];
    assign func3      = inst[FUNC3_MSB:FUNC3_LSB];
    assign func7      = inst[FUNC7_MSB:FUNC7_LSB];
    assign illegal    = inst_valid && (inst[1:0] != 2'b11);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level model of the expected fetch
// stream plus hand-computed checkpoints for reset, stall, redirect, wrap and reset-in-flight.
module tb_fetch_unit;
    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        illegal;

    fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .opcode      (opcode),
        .func3       (func3),
        .func7       (func7),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    int          vecs = 0;
    int          errs = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    bit          mem_zero = 1'b0;
    logic [31:0] mem_q[$];
    int          mem_due[$];
    logic [31:0] want[$];
    logic [31:0] grant_log[$];
    logic [31:0] m_next = 32'h0;
    logic [31:0] cmp_w;
    bit          ready_v = 1'b1;
    bit          redir_v = 1'b0;
    bit          fgnt_v = 1'b0;
    logic [31:0] rpc_v = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem_zero ? 32'h0 : (a ^ 32'h5A5A_3C33);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the expected fetch stream.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (imem_req && imem_gnt) begin
                chk("grant_addr", imem_addr, m_next);
                grant_log.push_back(imem_addr);
                want.push_back(m_next);
                m_next = m_next + 32'd4;
            end
            if (redirect) chk("req_during_redirect", imem_req, 32'd0);
            chk("buffer_cap", 32'(want.size() <= 2), 32'd1);
            if (inst_valid) begin
                chk("inst_expected", 32'(want.size() != 0), 32'd1);
                if (want.size() != 0) begin
                    cmp_w = mem_word(want[0]);
                    chk("inst_pc", inst_pc, want[0]);
                    chk("inst", inst, cmp_w);
                    chk("opcode", opcode, cmp_w[6:2]);
                    chk("func3", func3, cmp_w[14:12]);
                    chk("func7", func7, cmp_w[31:25]);
                    chk("illegal", illegal, cmp_w[1:0] != 2'b11);
                    if (inst_ready) void'(want.pop_front());
                end
            end else begin
                chk("empty_inst", inst, NOP_W);
                chk("empty_opcode", opcode, 32'h04);
                chk("empty_illegal", illegal, 32'd0);
            end
            if (redirect) begin
                want.delete();
                m_next = redirect_pc & ~32'd3;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (mem_q.size() != 0 && mem_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q.pop_front());
            void'(mem_due.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        redirect    = redir_v;
        redirect_pc = rpc_v;
        redir_v     = 1'b0;
        inst_ready  = ready_v;
        #1;
        imem_gnt = imem_req || fgnt_v;
        fgnt_v   = 1'b0;
        if (imem_gnt) begin
            mem_q.push_back(imem_addr);
            mem_due.push_back(cyc + mem_lat);
        end
        #1;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic hold_reset();
        rst         = 1'b0;
        redirect    = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redir_v     = 1'b0;
        fgnt_v      = 1'b0;
        mem_q.delete();
        mem_due.delete();
        want.delete();
        grant_log.delete();
        m_next = 32'h0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
    endtask

    initial begin
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;
        hold_reset();
        #2;
        chk("rst_req", imem_req, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", inst_valid, 32'd0);
        chk("rst_inst", inst, NOP_W);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_illegal", illegal, 32'd0);
        chk("rst_opcode", opcode, 32'h04);

        // Sequential fetch, grant every cycle, 1-cycle memory
        mem_lat = 1; ready_v = 1'b1;
        release_reset();
        step(); chk("t1_idle_req", imem_req, 32'd0);
        step(); chk("t1_req_c2", imem_req, 32'd1); chk("t1_addr_c2", imem_addr, 32'h0);
        step(); chk("t1_addr_c3", imem_addr, 32'h4); chk("t1_valid_c3", inst_valid, 32'd0);
        step(); chk("t1_valid_c4", inst_valid, 32'd1); chk("t1_pc_c4", inst_pc, 32'h0);
                chk("t1_inst_c4", inst, 32'h5A5A_3C33);
        run_to(12);
        chk("t1_third_grant", grant_log[2], 32'h8);

        // Decode stalled: buffer fills, requests stop, resume on ready
        hold_reset(); ready_v = 1'b0;
        release_reset();
        run_to(8);
        chk("t2_grants", grant_log.size(), 32'd2);
        chk("t2_req_off", imem_req, 32'd0);
        chk("t2_head_pc", inst_pc, 32'h0);
        ready_v = 1'b1;
        step(); chk("t2_pop_pc", inst_pc, 32'h0); chk("t2_req_c9", imem_req, 32'd0);
        step(); chk("t2_next_pc", inst_pc, 32'h4); chk("t2_resume_req", imem_req, 32'd1);
                chk("t2_resume_addr", imem_addr, 32'h8);

        // Redirect with two requests in flight
        hold_reset(); mem_lat = 3;
        release_reset();
        run_to(3);
        redir_v = 1'b1; rpc_v = 32'h0000_0100;
        step(); chk("t3_req_c4", imem_req, 32'd0); chk("t3_inflight", grant_log.size(), 32'd2);
        step(); chk("t3_req_c5", imem_req, 32'd0); chk("t3_valid_c5", inst_valid, 32'd0);
        step(); chk("t3_req_c6", imem_req, 32'd0); chk("t3_valid_c6", inst_valid, 32'd0);
        step(); chk("t3_req_c7", imem_req, 32'd1); chk("t3_addr_c7", imem_addr, 32'h100);
        run_to(10); chk("t3_valid_c10", inst_valid, 32'd0);
        step(); chk("t3_valid_c11", inst_valid, 32'd1); chk("t3_pc_c11", inst_pc, 32'h100);
        run_to(16);

        // Redirect coinciding with pop, rvalid and grant
        hold_reset(); mem_lat = 1;
        release_reset();
        run_to(3);
        redir_v = 1'b1; rpc_v = 32'h0000_0200; fgnt_v = 1'b1;
        step(); chk("t4_valid_c4", inst_valid, 32'd1); chk("t4_pc_c4", inst_pc, 32'h0);
                chk("t4_req_c4", imem_req, 32'd0);
        step(); chk("t4_req_c5", imem_req, 32'd0); chk("t4_valid_c5", inst_valid, 32'd0);
        step(); chk("t4_req_c6", imem_req, 32'd1); chk("t4_addr_c6", imem_addr, 32'h200);
        step(); chk("t4_valid_c7", inst_valid, 32'd0);
        step(); chk("t4_valid_c8", inst_valid, 32'd1); chk("t4_pc_c8", inst_pc, 32'h200);
        run_to(14);

        // Unaligned redirect target near the top of memory wraps to zero
        hold_reset();
        release_reset();
        run_to(2);
        redir_v = 1'b1; rpc_v = 32'hFFFF_FFFE;
        step(); chk("t5_req_c3", imem_req, 32'd0);
        step(); chk("t5_addr_c4", imem_addr, 32'hFFFF_FFFC); chk("t5_req_c4", imem_req, 32'd1);
        step(); chk("t5_addr_c5", imem_addr, 32'h0); chk("t5_req_c5", imem_req, 32'd1);
        step(); chk("t5_pc_c6", inst_pc, 32'hFFFF_FFFC); chk("t5_inst_c6", inst, 32'hA5A5_C3CF);
        step(); chk("t5_pc_c7", inst_pc, 32'h0); chk("t5_inst_c7", inst, 32'h5A5A_3C33);
        run_to(10);

        // Asynchronous reset with two requests outstanding
        hold_reset(); mem_lat = 3;
        release_reset();
        run_to(4);
        chk("t6_pre_addr", imem_addr, 32'h8);
        hold_reset();
        #1;
        chk("t6_req", imem_req, 32'd0);
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_valid", inst_valid, 32'd0);
        chk("t6_inst", inst, NOP_W);
        chk("t6_inst_pc", inst_pc, 32'h0);
        chk("t6_illegal", illegal, 32'd0);
        mem_zero = 1'b1; mem_lat = 1;
        release_reset();
        run_to(2); chk("t6_restart_req", imem_req, 32'd1); chk("t6_restart_addr", imem_addr, 32'h0);
        run_to(4); chk("t6_zero_valid", inst_valid, 32'd1); chk("t6_zero_inst", inst, 32'h0);
                   chk("t6_zero_illegal", illegal, 32'd1); chk("t6_zero_opcode", opcode, 32'h0);
        run_to(8);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of ctrl.
- Holds the PC and issues in-order requests to instruction memory.
- Buffers returned instructions in a small prefetch FIFO and presents the head instruction to decode/ctrl, with opcode/func3/func7 already sliced.
- Accepts PC redirects (jal/jalr/taken branch) from the execute side and flushes stale work.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, prefetch buffer entries; also the cap on outstanding + buffered instructions.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- redirect  in  1  PC change request (pc_sel != PC+4, already qualified by b).
- redirect_pc  in  XLEN  new fetch address; bits [1:0] forced to 0 internally.
- imem_req  out  1  memory request valid.
- imem_addr  out  XLEN  request address, word aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid; responses arrive in request order, never without a prior grant.
- imem_rdata  in  XLEN  instruction word.
- inst_valid  out  1  head instruction valid.
- inst_ready  in  1  decode consumes head this cycle.
- inst  out  XLEN  head instruction word (32'h0000_0013 NOP when empty).
- inst_pc  out  XLEN  PC of head instruction.
- opcode  out  5  inst[6:2].
- func3  out  3  inst[14:12].
- func7  out  7  inst[31:25].
- illegal  out  1  inst_valid && inst[1:0] != 2'b11.

Behaviour:
- Reset (rst low, any time, async): state IDLE, fetch_pc = RESET_PC, outstanding = 0, FIFO empty. Outputs: imem_req = 0, imem_addr = RESET_PC, inst_valid = 0, inst = NOP, inst_pc = RESET_PC, illegal = 0.
- States:
  - IDLE: one cycle after reset release, then RUN.
  - RUN: normal fetch.
  - DRAIN: discard in-flight responses after a redirect.
- Issue rule (RUN only): imem_req = (outstanding + fifo_count) < FIFO_DEPTH. imem_addr = fetch_pc.
- On imem_req && imem_gnt: fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0) and outstanding++.
- Capacity guarantee: the issue rule means every response has a free FIFO slot; imem_rvalid is never backpressured.
- Handshake: imem_addr holds stable while imem_req && !imem_gnt, except on redirect, where an ungranted request may be withdrawn.
- Response: on imem_rvalid in RUN, push {rdata, pc} and decrement outstanding. The entry is visible on inst_valid the next cycle; there is no bypass.
- Latency: first imem_req is asserted 2 cycles after rst rises. Minimum gnt-to-inst_valid latency is 1 cycle plus memory latency.
- Pop: inst_valid && inst_ready removes the head. Push and pop in the same cycle are allowed; count is unchanged.
- Redirect (any state except IDLE, priority over everything):
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - FIFO flushed, after honouring a same-cycle pop.
  - imem_req is forced to 0 that cycle.
  - A grant occurring in the redirect cycle counts as outstanding.
  - A rvalid in the redirect cycle is dropped.
  - Next state is DRAIN if outstanding after update > 0, else RUN.
- DRAIN: no requests are issued. Each imem_rvalid is discarded and decrements outstanding. Go to RUN when outstanding reaches 0. A further redirect in DRAIN only updates fetch_pc.
- Field slicing is combinational from the FIFO head. When empty, fields come from NOP (opcode 5'b00100, func3 0, func7 0).

Decomposition:
- fetch_pkg:
  - fetch_state_t enum {IDLE, RUN, DRAIN}.
  - NOP constant 32'h0000_0013.
  - Field bit-position localparams for opcode, func3 and func7.
- Sub-module fetch_fifo: parameterised DEPTH/WIDTH, synchronous push/pop/flush, count output, async active-low reset.
- All other logic stays in fetch_unit.

Test Plan:
1. Reset release, memory grants every cycle, rvalid 1 cycle later:
   - imem_addr sequence 0x0, 0x4, 0x8.
   - inst_pc matches.
   - inst_valid first high 4 cycles after rst rises (assuming inst_ready=1).
2. inst_ready = 0 with gnt always high:
   - Exactly 2 requests are granted, then imem_req drops to 0.
   - FIFO holds PCs 0x0 and 0x4.
   - Raising inst_ready resumes fetch at 0x8.
3. Redirect to 0x100 with 2 outstanding:
   - State goes to DRAIN; the next 2 rvalids are discarded (inst_valid stays 0).
   - The next request address is 0x100.
   - First delivered inst_pc = 0x100.
4. Redirect in the same cycle as rvalid, grant, and inst_ready pop:
   - Head is popped, rvalid data is dropped, the granted request is drained.
   - No instruction from the old path appears afterwards.
5. Wrap: redirect_pc = 32'hFFFF_FFFE:
   - Fetch addresses 0xFFFF_FFFC then 0x0000_0000.
6. rst asserted while outstanding = 2:
   - All outputs take their reset values immediately.
   - Post-reset fetch restarts at RESET_PC.
   - rdata 32'h0000_0000 returns illegal = 1, opcode 0.
